// File: rtl/sync_gen_pkg.sv
// Shared constants and state encoding for the periodic sync pulse generator.
package sync_gen_pkg;

  localparam int PERIOD_W_DEFAULT = 32;
  localparam int PULSE_LEN_MAX    = 255;
  localparam int PULSE_CNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sync_state_t;

  // Out-of-range pulse lengths are pulled into 1..PULSE_LEN_MAX.
  function automatic int clamp_pulse_len(input int len);
    if (len < 1)             return 1;
    if (len > PULSE_LEN_MAX) return PULSE_LEN_MAX;
    return len;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for software-register level triggers.
module rise_edge_detect (
  input  logic user_clk,
  input  logic user_rst,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge user_clk) begin
    if (user_rst) din_d <= 1'b0;
    else          din_d <= din;
  end

  // The edge output is named 'rise' because 'edge' is a reserved word.
  assign rise = din & ~din_d;

endmodule

// File: rtl/sync_gen_core.sv
// Periodic sync pulse generator: armed by a rising edge of 'arm', fires every
// period_active cycles and re-samples sync_period only at each wrap.
module sync_gen_core
  import sync_gen_pkg::*;
#(
  parameter int PERIOD_W  = PERIOD_W_DEFAULT,
  parameter int PULSE_LEN = 1
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [PERIOD_W-1:0] sync_period,
  input  logic                arm,
  output logic                sync_out,
  output logic [PERIOD_W-1:0] sync_count,
  output logic [PERIOD_W-1:0] period_active,
  output logic                running
);

  localparam int PULSE_EFF = clamp_pulse_len(PULSE_LEN);
  localparam int CMP_W     = PERIOD_W + PULSE_CNT_W;

  sync_state_t             state;
  logic [PERIOD_W-1:0]     cnt;
  logic [PULSE_CNT_W-1:0]  pulse_left;
  logic                    arm_edge;
  logic                    restart;
  logic                    wrap;
  logic                    fire;
  logic                    stop;
  logic [CMP_W-1:0]        period_ext;
  logic [PULSE_CNT_W-1:0]  pulse_load;

  rise_edge_detect u_arm_edge (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .din      (arm),
    .rise     (arm_edge)
  );

  // Every event loads its period from sync_period, so the pulse cap uses it too.
  always_comb begin
    restart    = arm_edge && (sync_period != '0);
    wrap       = (state == RUN) && (cnt == period_active - PERIOD_W'(1));
    fire       = restart || (wrap && (sync_period != '0));
    stop       = !restart && wrap && (sync_period == '0);
    period_ext = CMP_W'(sync_period);
    if (period_ext < CMP_W'(PULSE_EFF))
      pulse_load = PULSE_CNT_W'(period_ext - CMP_W'(1));
    else
      pulse_load = PULSE_CNT_W'(PULSE_EFF - 1);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state         <= IDLE;
      running       <= 1'b0;
      cnt           <= '0;
      period_active <= '0;
      pulse_left    <= '0;
      sync_out      <= 1'b0;
      sync_count    <= '0;
    end else begin
      if (restart) begin
        state         <= RUN;
        running       <= 1'b1;
        cnt           <= '0;
        period_active <= sync_period;
      end else if (wrap) begin
        cnt           <= '0;
        period_active <= sync_period;
        if (sync_period == '0) begin
          state   <= IDLE;
          running <= 1'b0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + PERIOD_W'(1);
      end

      // pulse_left counts the high cycles still owed after the current one.
      if (fire) begin
        sync_out   <= 1'b1;
        pulse_left <= pulse_load;
        sync_count <= sync_count + PERIOD_W'(1);
      end else if (stop) begin
        sync_out   <= 1'b0;
        pulse_left <= '0;
      end else if (pulse_left != '0) begin
        pulse_left <= pulse_left - PULSE_CNT_W'(1);
      end else begin
        sync_out <= 1'b0;
      end
    end
  end

endmodule
